// File: rtl/approx_mult_engine.sv
// Iterative approximate unsigned multiplier: normalise, multiply top KEEP_W bits, denormalise.
// Optional out_exact flag enabled by defining APPROX_MULT_EXACT_FLAG_EN.
module approx_mult_engine #(
   parameter int DATA_W = 16,
   parameter int KEEP_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_a,
   input  logic [DATA_W-1:0]     in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DATA_W-1:0]   out_p,
   output logic                  busy
`ifdef APPROX_MULT_EXACT_FLAG_EN
   ,
   output logic                  out_exact
`endif
);

   localparam int LW = $clog2(DATA_W);
   localparam int SW = $clog2(2*DATA_W-1);
   localparam int SH = 2*DATA_W - 2*KEEP_W;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_NORM   = 3'd1;
   localparam logic [2:0] ST_MULT   = 3'd2;
   localparam logic [2:0] ST_DENORM = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]            r_state;
   logic [DATA_W-1:0]     r_ra;
   logic [DATA_W-1:0]     r_rb;
   logic [LW-1:0]         r_la;
   logic [LW-1:0]         r_lb;
   logic [2*DATA_W-1:0]   r_r;
   logic [SW-1:0]         r_s;

   logic [KEEP_W-1:0]     w_ka;
   logic [KEEP_W-1:0]     w_kb;
   logic [2*KEEP_W-1:0]   w_p;
   logic [2*DATA_W-1:0]   w_r_init;
   logic [SW-1:0]         w_s_init;

   assign w_ka     = r_ra[DATA_W-1 -: KEEP_W];
   assign w_kb     = r_rb[DATA_W-1 -: KEEP_W];
   assign w_p      = (2*KEEP_W)'(w_ka) * (2*KEEP_W)'(w_kb);
   assign w_r_init = (2*DATA_W)'(w_p) << SH;
   assign w_s_init = SW'(r_la) + SW'(r_lb);

`ifdef APPROX_MULT_EXACT_FLAG_EN
   logic                  r_exact;
   logic [DATA_W-1:0]     w_a_rem;
   logic [DATA_W-1:0]     w_b_rem;
   logic                  w_exact;

   // Bits below the kept field; a shift by KEEP_W leaves zero when KEEP_W==DATA_W.
   assign w_a_rem = r_ra << KEEP_W;
   assign w_b_rem = r_rb << KEEP_W;
   assign w_exact = (w_a_rem == '0) && (w_b_rem == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exact <= 1'b0;
      end else if (r_state == ST_IDLE && in_valid) begin
         r_exact <= 1'b1;
      end else if (r_state == ST_MULT) begin
         r_exact <= w_exact;
      end
   end

   assign out_exact = r_exact;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_la    <= '0;
         r_lb    <= '0;
         r_r     <= '0;
         r_s     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_ra <= in_a;
                  r_rb <= in_b;
                  r_la <= '0;
                  r_lb <= '0;
                  if (in_a == '0 || in_b == '0) begin
                     r_r     <= '0;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_NORM;
                  end
               end
            end
            ST_NORM: begin
               if (r_ra[DATA_W-1] && r_rb[DATA_W-1]) begin
                  r_state <= ST_MULT;
               end else begin
                  if (!r_ra[DATA_W-1]) begin
                     r_ra <= r_ra << 1;
                     r_la <= r_la + LW'(1);
                  end
                  if (!r_rb[DATA_W-1]) begin
                     r_rb <= r_rb << 1;
                     r_lb <= r_lb + LW'(1);
                  end
               end
            end
            ST_MULT: begin
               r_r     <= w_r_init;
               r_s     <= w_s_init;
               r_state <= ST_DENORM;
            end
            ST_DENORM: begin
               if (r_s == '0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_r <= r_r >> 1;
                  r_s <= r_s - SW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign out_p     = r_r;

endmodule

// File: tb/tb_approx_mult_engine.sv
// Scoreboard bench for approx_mult_engine (DATA_W=16, KEEP_W=8).
module tb_approx_mult_engine;

   localparam int D = 16;
   localparam int K = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [D-1:0]      in_a;
   logic [D-1:0]      in_b;
   logic              out_valid;
   logic              out_ready;
   logic [2*D-1:0]    out_p;
   logic              busy;
`ifdef APPROX_MULT_EXACT_FLAG_EN
   logic              out_exact;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [2*D-1:0] exp_p_q[$];
   int             exp_lat_q[$];
   bit             exp_ex_q[$];

   always #5 clk = ~clk;

   approx_mult_engine #(.DATA_W(D), .KEEP_W(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
`ifdef APPROX_MULT_EXACT_FLAG_EN
      ,
      .out_exact (out_exact)
`endif
   );

   function automatic int lz(input logic [D-1:0] v);
      int n = D;
      for (int i = 0; i < D; i++) if (v[i]) n = D - 1 - i;
      return n;
   endfunction

   function automatic logic [2*D-1:0] model_p(input logic [D-1:0] a, input logic [D-1:0] b);
      logic [D-1:0]   na, nb;
      logic [2*D-1:0] p;
      int la, lb;
      if (a == '0 || b == '0) return '0;
      la = lz(a); lb = lz(b);
      na = a << la; nb = b << lb;
      p = (2*D)'(na >> (D-K)) * (2*D)'(nb >> (D-K));
      return (p << (2*D-2*K)) >> (la + lb);
   endfunction

   function automatic int model_lat(input logic [D-1:0] a, input logic [D-1:0] b);
      int la, lb;
      if (a == '0 || b == '0) return 1;
      la = lz(a); lb = lz(b);
      return ((la > lb) ? la : lb) + la + lb + 4;
   endfunction

   function automatic bit model_exact(input logic [D-1:0] a, input logic [D-1:0] b);
      logic [D-1:0] ra, rb;
      if (a == '0 || b == '0) return 1'b1;
      ra = (a << lz(a)) << K;
      rb = (b << lz(b)) << K;
      return (ra == '0) && (rb == '0);
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_pair(input logic [D-1:0] a, input logic [D-1:0] b,
                            input logic [2*D-1:0] ep, input int el, input bit ee);
      int w = 0;
      while (!in_ready && w < 300) begin
         @(posedge clk); #1; w++;
      end
      if (!in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end
      exp_p_q.push_back(ep); exp_lat_q.push_back(el); exp_ex_q.push_back(ee);
      in_valid = 1'b1; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) begin
         n_tests++; n_fail++;
         $display("FAIL out_timeout: out_valid=%0b required 1", out_valid);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
      n_tests++; if (out_p !== '0) begin n_fail++; $display("FAIL rst_out_p: got %h want 0", out_p); end
`ifdef APPROX_MULT_EXACT_FLAG_EN
      n_tests++; if (out_exact !== 1'b0) begin n_fail++; $display("FAIL rst_out_exact: got %0b want 0", out_exact); end
`endif
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [D-1:0]   ta[6] = '{16'h8000, 16'h0003, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0001};
      logic [D-1:0]   tb[6] = '{16'h8000, 16'h0005, 16'hFFFF, 16'h1234, 16'h0001, 16'h0001};
      logic [2*D-1:0] tp[6] = '{32'h4000_0000, 32'h0000_000F, 32'hFE01_0000, 32'h0, 32'h0000_00FF, 32'h0000_0001};
      int             tl[6] = '{4, 45, 4, 1, 42, 49};
      bit             te[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         int lat;
         logic [2*D-1:0] ep;
         int el;
         bit ee;
         send_pair(ta[i], tb[i], tp[i], tl[i], te[i]);
         wait_out(lat);
         ep = exp_p_q.pop_front(); el = exp_lat_q.pop_front(); ee = exp_ex_q.pop_front();
         n_tests++; if (out_p !== ep) begin n_fail++; $display("FAIL dir%0d_p: got %h want %h", i, out_p, ep); end
         n_tests++; if (lat !== el) begin n_fail++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, el); end
`ifdef APPROX_MULT_EXACT_FLAG_EN
         n_tests++; if (out_exact !== ee) begin n_fail++; $display("FAIL dir%0d_exact: got %0b want %0b", i, out_exact, ee); end
`endif
         consume();
      end
   endtask

   task automatic test_hold();
      int lat;
      logic [2*D-1:0] ep;
      int el;
      bit ee;
      send_pair(16'h0000, 16'h1234, 32'h0, 1, 1'b1);
      wait_out(lat);
      ep = exp_p_q.pop_front(); el = exp_lat_q.pop_front(); ee = exp_ex_q.pop_front();
      n_tests++; if (lat !== el) begin n_fail++; $display("FAIL hold_lat: got %0d want %0d", lat, el); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_p !== ep || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_c%0d: valid=%0b p=%h in_ready=%0b want 1/%h/0", c, out_valid, out_p, in_ready, ep);
         end
      end
`ifdef APPROX_MULT_EXACT_FLAG_EN
      n_tests++; if (out_exact !== ee) begin n_fail++; $display("FAIL hold_exact: got %0b want %0b", out_exact, ee); end
`endif
      consume();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: in_ready=%0b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [2*D-1:0] ep;
      int el;
      send_pair(16'h0003, 16'h0005, 32'h0000_000F, 45, 1'b1);
      repeat (25) begin @(posedge clk); #1; end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %0b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %0b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b want 0", busy); end
      n_tests++; if (out_p !== '0) begin n_fail++; $display("FAIL mid_out_p: got %h want 0", out_p); end
      #1 rst = 1'b0;
      exp_p_q.delete(); exp_lat_q.delete(); exp_ex_q.delete();
      @(posedge clk); #1;
      send_pair(16'hFFFF, 16'hFFFF, 32'hFE01_0000, 4, 1'b0);
      wait_out(lat);
      ep = exp_p_q.pop_front(); el = exp_lat_q.pop_front(); void'(exp_ex_q.pop_front());
      n_tests++; if (out_p !== ep) begin n_fail++; $display("FAIL mid_next_p: got %h want %h", out_p, ep); end
      n_tests++; if (lat !== el) begin n_fail++; $display("FAIL mid_next_lat: got %0d want %0d", lat, el); end
      consume();
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         logic [D-1:0] a, b;
         logic [2*D-1:0] ep;
         int lat, el;
         bit ee;
         a = D'($urandom) >> $urandom_range(0, D-1);
         b = D'($urandom) >> $urandom_range(0, D-1);
         if (i == 3) a = 16'h1234;
         send_pair(a, b, model_p(a, b), model_lat(a, b), model_exact(a, b));
         wait_out(lat);
         ep = exp_p_q.pop_front(); el = exp_lat_q.pop_front(); ee = exp_ex_q.pop_front();
         n_tests++; if (out_p !== ep) begin n_fail++; $display("FAIL rnd%0d_p a=%h b=%h: got %h want %h", i, a, b, out_p, ep); end
         n_tests++; if (lat !== el) begin n_fail++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, lat, el); end
`ifdef APPROX_MULT_EXACT_FLAG_EN
         n_tests++; if (out_exact !== ee) begin n_fail++; $display("FAIL rnd%0d_exact: got %0b want %0b", i, out_exact, ee); end
`endif
         consume();
      end
   endtask

   task automatic test_back_to_back();
      logic [D-1:0] pa[3] = '{16'h0003, 16'h0000, 16'hFFFF};
      logic [D-1:0] pb[3] = '{16'h0005, 16'h00AB, 16'h8001};
      int acc = 0;
      int got = 0;
      fork
         begin
            in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
            for (int cyc = 0; cyc < 1500 && acc < 3; cyc++) begin
               bit hs;
               hs = in_ready;
               n_tests++;
               if (in_ready === 1'b1 && busy !== 1'b0) begin
                  n_fail++; $display("FAIL b2b_accept_busy: in_ready=%0b busy=%0b", in_ready, busy);
               end
               @(posedge clk); #1;
               if (hs) begin
                  exp_p_q.push_back(model_p(pa[acc], pb[acc]));
                  acc++;
                  if (acc < 3) begin in_a = pa[acc]; in_b = pb[acc]; end
                  else in_valid = 1'b0;
               end
            end
            in_valid = 1'b0;
         end
         begin
            bit tog = 1'b0;
            for (int cyc = 0; cyc < 2000 && got < 3; cyc++) begin
               bit fire;
               logic [2*D-1:0] obs, ep;
               tog = ~tog;
               out_ready = tog;
               fire = out_valid && tog;
               obs = out_p;
               @(posedge clk); #1;
               if (fire) begin
                  got++;
                  n_tests++;
                  if (exp_p_q.size() == 0) begin
                     n_fail++; $display("FAIL b2b_extra: got %h want none", obs);
                  end else begin
                     ep = exp_p_q.pop_front();
                     if (obs !== ep) begin n_fail++; $display("FAIL b2b_p%0d: got %h want %h", got, obs, ep); end
                  end
               end
            end
            out_ready = 1'b0;
         end
      join
      n_tests++; if (got !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", got); end
      repeat (5) begin @(posedge clk); #1; end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup: out_valid=%0b want 0", out_valid); end
      n_tests++; if (exp_p_q.size() != 0) begin n_fail++; $display("FAIL b2b_left: %0d pending want 0", exp_p_q.size()); end
      exp_lat_q.delete(); exp_ex_q.delete();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/approx_mult_engine.md
Name: approx_mult_engine

Overview:
Self-contained, parametrised approximate multiplier for unsigned operands.
- Normalises each operand by iterative left shift until its MSB is 1, counting the shifts.
- Multiplies only the top KEEP_W bits of each normalised operand.
- Restores scale with an iterative right shift by the combined shift count.
- Generalises the fixed 16-bit/8-bit RAM-fed datapath: internal FSM, valid/ready streaming on both sides, arbitrary widths, zero-operand bypass.

Parameters:
DATA_W, 16, operand width in bits (>= 2).
KEEP_W, 8, effective bits kept per operand for the multiply (2 <= KEEP_W <= DATA_W).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous and active-high.
in_valid  input  1  operand pair valid.
in_ready  output  1  engine can accept a pair; high only in IDLE.
in_a  input  DATA_W  operand A, unsigned.
in_b  input  DATA_W  operand B, unsigned.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
out_p  output  2*DATA_W  approximate product.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all internal registers and counters = 0; out_p=0; out_valid=0; in_ready=1; busy=0. Reset asserted mid-operation aborts immediately; the partial result is discarded.
- IDLE: in_valid&&in_ready latches in_a/in_b into shift regs RA/RB and clears counters LA/LB (width clog2(DATA_W)).
  - If either operand == 0: out_p<=0, go to DONE.
  - Otherwise go to NORM.
- NORM: per cycle, RA shifts left 1 and LA increments if RA[MSB]==0; RB/LB likewise, in parallel. When both MSBs==1, go to MULT without shifting. NORM occupies max(LA,LB)+1 cycles.
- MULT (1 cycle):
  - P = RA[DATA_W-1:DATA_W-KEEP_W] * RB[DATA_W-1:DATA_W-KEEP_W]; width 2*KEEP_W, full precision.
  - Result reg R (2*DATA_W) <= P << (2*DATA_W-2*KEEP_W).
  - Down counter S (width clog2(2*DATA_W-1)) <= LA+LB.
  - Go to DENORM.
- DENORM: if S==0 go to DONE, else R<=R>>1 and S<=S-1. Occupies LA+LB+1 cycles.
- DONE: out_valid=1, out_p=R, held stable while out_ready==0. On out_ready, go to IDLE. Next pair cannot be accepted in the same cycle; in_ready rises the cycle after.
- Latency, handshake edge to out_valid: nonzero operands max(LA,LB)+LA+LB+4 cycles; zero operand 1 cycle.
- Result is exact when every bit below the top KEEP_W of each normalised operand is 0; otherwise truncated toward zero. Bits discarded by the right shift are always 0, so no extra error arises there.
- KEEP_W==DATA_W: exact multiplier.
- in_a/in_b ignored outside IDLE. out_ready ignored outside DONE.

Optional Feature:
Macro APPROX_MULT_EXACT_FLAG_EN.
- Defined: adds output out_exact (1 bit), reset 0, valid with out_valid.
  - out_exact=1 when both normalised operands have zero bits below the kept field.
  - Also 1 on the zero-operand bypass.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-DENORM: rst pulse -> asynchronously state=IDLE, in_ready=1, out_valid=0, busy=0. Next pair processes normally.
- DATA_W=16, KEEP_W=8, a=0x8000, b=0x8000 -> out_p=0x4000_0000, out_valid 4 cycles after handshake, out_exact=1.
- a=0x0003, b=0x0005 -> LA=14, LB=13; out_p=0x0000_000F after 45 cycles; out_exact=1.
- a=0xFFFF, b=0xFFFF -> out_p=0xFE01_0000 (exact 0xFFFE_0001), out_exact=0.
- a=0x0000, b=0x1234 -> out_p=0, out_valid 1 cycle after handshake. Then hold out_ready=0 for 5 cycles -> out_valid and out_p stable, in_ready=0.
- Back-to-back stream, in_valid held high with 3 pairs, out_ready toggling -> each pair accepted only in IDLE, results in order, none dropped or duplicated.
